// File: rtl/tile_map_reader_pkg.sv
// Shared constants and types for the tile map video path.
// Covers map geometry, config register addresses and the control-bit layout.
package tile_map_reader_pkg;

    localparam int MAP_BITS       = 6;
    localparam int TILE_IDX_BITS  = 7;
    localparam int PIXEL_BITS     = 4;
    localparam int TILE_SHIFT     = 3;
    localparam int WORLD_BITS     = 9;
    localparam int COORD_BITS     = 10;
    localparam int CFG_ADDR_BITS  = 2;
    localparam int CFG_DATA_BITS  = 16;
    localparam int CTRL_BITS      = 2;
    localparam int NUM_CFG_REGS   = 3;
    localparam int TILE_ADDR_BITS = 2 * MAP_BITS;
    localparam int PAT_ADDR_BITS  = TILE_IDX_BITS + 2 * TILE_SHIFT;

    localparam logic [CFG_ADDR_BITS-1:0] CFG_SCROLL_X = 2'd0;
    localparam logic [CFG_ADDR_BITS-1:0] CFG_SCROLL_Y = 2'd1;
    localparam logic [CFG_ADDR_BITS-1:0] CFG_CTRL     = 2'd2;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_TRANSP_BIT = 1;

    typedef struct packed {
        logic [WORLD_BITS-1:0] scroll_x;
        logic [WORLD_BITS-1:0] scroll_y;
        logic [CTRL_BITS-1:0]  ctrl;
    } scroll_cfg_t;

    // Screen coordinate plus scroll, wrapping at the 512-pixel world size.
    function automatic logic [WORLD_BITS-1:0] wrap_add(
        input logic [COORD_BITS-1:0] screen,
        input logic [WORLD_BITS-1:0] scroll
    );
        return screen[WORLD_BITS-1:0] + scroll;
    endfunction

endpackage

// File: rtl/tile_map_reader_if.sv
// Bundle of config, pixel, memory and output signals of the tile map reader.
// slave is the reader itself; master is whatever drives it.
interface tile_map_reader_if;
    import tile_map_reader_pkg::*;

    logic                      cfg_wen;
    logic [CFG_ADDR_BITS-1:0]  cfg_addr;
    logic [CFG_DATA_BITS-1:0]  cfg_wdata;
    logic                      frame_start;
    logic                      in_valid;
    logic [COORD_BITS-1:0]     in_x;
    logic [COORD_BITS-1:0]     in_y;
    logic                      tile_ren;
    logic [TILE_ADDR_BITS-1:0] tile_raddr;
    logic [TILE_IDX_BITS-1:0]  tile_rdata;
    logic                      pat_ren;
    logic [PAT_ADDR_BITS-1:0]  pat_raddr;
    logic [PIXEL_BITS-1:0]     pat_rdata;
    logic                      out_valid;
    logic [PIXEL_BITS-1:0]     out_pixel;
    logic                      out_opaque;

    modport master (
        output cfg_wen, cfg_addr, cfg_wdata, frame_start,
        output in_valid, in_x, in_y, tile_rdata, pat_rdata,
        input  tile_ren, tile_raddr, pat_ren, pat_raddr,
        input  out_valid, out_pixel, out_opaque
    );

    modport slave (
        input  cfg_wen, cfg_addr, cfg_wdata, frame_start,
        input  in_valid, in_x, in_y, tile_rdata, pat_rdata,
        output tile_ren, tile_raddr, pat_ren, pat_raddr,
        output out_valid, out_pixel, out_opaque
    );

endinterface

// File: rtl/tile_scroll_regs.sv
// Double-buffered scroll/control registers: CPU writes land in the shadow set,
// and the active set copies the shadow set on each frame_start.
module tile_scroll_regs
    import tile_map_reader_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_wen_i,
    input  logic [CFG_ADDR_BITS-1:0] cfg_addr_i,
    input  logic [CFG_DATA_BITS-1:0] cfg_wdata_i,
    input  logic                     frame_start_i,
    output scroll_cfg_t              active_o
);

    scroll_cfg_t               shadow_q;
    scroll_cfg_t               active_q;
    logic [NUM_CFG_REGS-1:0]   sel;
    logic                      unused_wdata;

    generate
        for (genvar gi = 0; gi < NUM_CFG_REGS; gi++) begin : g_sel
            assign sel[gi] = cfg_wen_i && (cfg_addr_i == CFG_ADDR_BITS'(gi));
        end
    endgenerate

    assign unused_wdata = ^cfg_wdata_i[CFG_DATA_BITS-1:WORLD_BITS];

    // active copies the shadow value as it was before any write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (frame_start_i) begin
                active_q <= shadow_q;
            end
            if (sel[CFG_SCROLL_X]) begin
                shadow_q.scroll_x <= cfg_wdata_i[WORLD_BITS-1:0];
            end
            if (sel[CFG_SCROLL_Y]) begin
                shadow_q.scroll_y <= cfg_wdata_i[WORLD_BITS-1:0];
            end
            if (sel[CFG_CTRL]) begin
                shadow_q.ctrl <= cfg_wdata_i[CTRL_BITS-1:0];
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/tile_map_reader.sv
// Scrolled tile map fetch: tile-index read, pattern read, then a registered
// colour index with opacity, fixed three-cycle latency and no backpressure.
module tile_map_reader
    import tile_map_reader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    tile_map_reader_if.slave bus
);

    scroll_cfg_t           active;
    logic [WORLD_BITS-1:0] wx;
    logic [WORLD_BITS-1:0] wy;
    logic                  unused_coord;

    logic                  s1_valid_q;
    logic                  s1_enable_q;
    logic                  s1_transp_q;
    logic [TILE_SHIFT-1:0] s1_fine_x_q;
    logic [TILE_SHIFT-1:0] s1_fine_y_q;
    logic                  s2_valid_q;
    logic                  s2_enable_q;
    logic                  s2_transp_q;
    logic                  out_valid_q;
    logic [PIXEL_BITS-1:0] out_pixel_q;
    logic                  out_opaque_q;
    logic [PIXEL_BITS-1:0] out_pixel_d;
    logic                  out_opaque_d;

    tile_scroll_regs u_regs (
        .clk           (clk),
        .reset         (reset),
        .cfg_wen_i     (bus.cfg_wen),
        .cfg_addr_i    (bus.cfg_addr),
        .cfg_wdata_i   (bus.cfg_wdata),
        .frame_start_i (bus.frame_start),
        .active_o      (active)
    );

    assign wx = wrap_add(bus.in_x, active.scroll_x);
    assign wy = wrap_add(bus.in_y, active.scroll_y);
    assign unused_coord = bus.in_x[COORD_BITS-1] ^ bus.in_y[COORD_BITS-1];

    // Stage 0: tile-index read straight from the incoming coordinate
    assign bus.tile_raddr = {wy[WORLD_BITS-1:TILE_SHIFT], wx[WORLD_BITS-1:TILE_SHIFT]};
    assign bus.tile_ren   = bus.in_valid & active.ctrl[CTRL_ENABLE_BIT] & ~reset;

    // Stage 1: pattern read using the tile index returned this cycle
    assign bus.pat_raddr = {bus.tile_rdata, s1_fine_y_q, s1_fine_x_q};
    assign bus.pat_ren   = s1_valid_q & s1_enable_q;

    always_comb begin
        out_pixel_d  = '0;
        out_opaque_d = 1'b0;
        if (s2_enable_q) begin
            out_pixel_d  = bus.pat_rdata;
            out_opaque_d = ~(s2_transp_q && (bus.pat_rdata == '0));
        end
    end

    // Enable/transparency ride along with each pixel so a mid-pipeline
    // frame_start only affects pixels that enter afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_enable_q  <= 1'b0;
            s1_transp_q  <= 1'b0;
            s1_fine_x_q  <= '0;
            s1_fine_y_q  <= '0;
            s2_valid_q   <= 1'b0;
            s2_enable_q  <= 1'b0;
            s2_transp_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            out_opaque_q <= 1'b0;
        end else begin
            s1_valid_q   <= bus.in_valid;
            s1_enable_q  <= active.ctrl[CTRL_ENABLE_BIT];
            s1_transp_q  <= active.ctrl[CTRL_TRANSP_BIT];
            s1_fine_x_q  <= wx[TILE_SHIFT-1:0];
            s1_fine_y_q  <= wy[TILE_SHIFT-1:0];
            s2_valid_q   <= s1_valid_q;
            s2_enable_q  <= s1_enable_q;
            s2_transp_q  <= s1_transp_q;
            out_valid_q  <= s2_valid_q;
            out_pixel_q  <= out_pixel_d;
            out_opaque_q <= out_opaque_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_pixel  = out_pixel_q;
    assign bus.out_opaque = out_opaque_q;

endmodule

// File: tb/tb_tile_map_reader.sv
// Randomised and directed bench for tile_map_reader with a queue scoreboard
// fed by an arithmetic reference model of scrolling, memories and config.
module tb_tile_map_reader;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    tile_map_reader_if bus ();

    tile_map_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int   due;
        int   pix;
        int   opq;
    } exp_t;

    exp_t sb[$];

    logic [6:0] tile_mem [4096];
    logic [3:0] pat_mem  [8192];

    // reference config state
    int s_sx, s_sy, s_ctrl;
    int m_sx, m_sy, m_ctrl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // external memories answer one cycle after a read enable
    always @(posedge clk) begin
        if (bus.tile_ren) bus.tile_rdata <= tile_mem[bus.tile_raddr];
        if (bus.pat_ren)  bus.pat_rdata  <= pat_mem[bus.pat_raddr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a pixel
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc, e.due);
                        chk("out_pixel", int'(bus.out_pixel), e.pix);
                        chk("out_opaque", int'(bus.out_opaque), e.opq);
                        $display("pix cyc=%0d pixel=%0d opaque=%0d", cyc, bus.out_pixel, bus.out_opaque);
                    end
                end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    chk("missing_out_valid", 0, 1);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_x        = '0;
        bus.in_y        = '0;
        bus.cfg_wen     = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_wdata   = '0;
        bus.frame_start = 1'b0;
    endtask

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input logic v, input logic [9:0] x, input logic [9:0] y,
                         input logic wen, input logic [1:0] a, input logic [15:0] d,
                         input logic fs);
        int wx, wy, taddr, idx, p, en, tr;
        exp_t e;
        bus.in_valid    = v;
        bus.in_x        = x;
        bus.in_y        = y;
        bus.cfg_wen     = wen;
        bus.cfg_addr    = a;
        bus.cfg_wdata   = d;
        bus.frame_start = fs;
        wx    = (int'(x) % 512 + m_sx) % 512;
        wy    = (int'(y) % 512 + m_sy) % 512;
        en    = m_ctrl % 2;
        tr    = m_ctrl / 2;
        taddr = (wy / 8) * 64 + (wx / 8);
        #1;
        chk("tile_ren", int'(bus.tile_ren), (v && en == 1) ? 1 : 0);
        if (v && en == 1) chk("tile_raddr", int'(bus.tile_raddr), taddr);
        if (v) begin
            idx   = int'(tile_mem[taddr]);
            p     = int'(pat_mem[idx * 64 + (wy % 8) * 8 + (wx % 8)]);
            e.due = cyc + 3;
            e.pix = (en == 1) ? p : 0;
            e.opq = (en == 1 && !(tr == 1 && p == 0)) ? 1 : 0;
            sb.push_back(e);
        end
        if (fs) begin
            m_sx   = s_sx;
            m_sy   = s_sy;
            m_ctrl = s_ctrl;
        end
        if (wen) begin
            case (a)
                2'd0: s_sx   = int'(d) % 512;
                2'd1: s_sy   = int'(d) % 512;
                2'd2: s_ctrl = int'(d) % 4;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic px(input int x, input int y);
        drive(1'b1, 10'(x), 10'(y), 1'b0, 2'd0, 16'd0, 1'b0);
    endtask

    task automatic cfg(input int a, input int d);
        drive(1'b0, 10'd0, 10'd0, 1'b1, 2'(a), 16'(d), 1'b0);
    endtask

    task automatic fstart();
        drive(1'b0, 10'd0, 10'd0, 1'b0, 2'd0, 16'd0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle_inputs();
        sb.delete();
        s_sx = 0; s_sy = 0; s_ctrl = 0;
        m_sx = 0; m_sy = 0; m_ctrl = 0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.tile_rdata = '0;
        bus.pat_rdata  = '0;
        idle_inputs();
        for (int i = 0; i < 4096; i++) tile_mem[i] = 7'($urandom);
        for (int i = 0; i < 8192; i++) pat_mem[i]  = 4'($urandom);
        tile_mem[12'h042] = 7'd5;
        pat_mem[329]      = 4'hA;
        tile_mem[0]       = 7'd0;
        pat_mem[0]        = 4'h0;

        @(posedge clk);
        #1;
        do_reset(3);
        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_pixel", int'(bus.out_pixel), 0);
        chk("rst_out_opaque", int'(bus.out_opaque), 0);
        chk("rst_pat_ren", int'(bus.pat_ren), 0);
        @(posedge clk);
        #1;
        px(17, 9);                 // disabled after reset: no tile read, transparent 0

        cfg(2, 1);
        fstart();
        px(17, 9);
        chk("pat_ren", int'(bus.pat_ren), 1);
        chk("pat_raddr", int'(bus.pat_raddr), 329);

        cfg(0, 500);
        cfg(1, 511);
        fstart();
        px(20, 1);

        cfg(0, 8);
        cfg(1, 0);
        px(20, 1);                 // still old scroll
        drive(1'b1, 10'd3, 10'd4, 1'b1, 2'd0, 16'd16, 1'b1);
        px(3, 4);
        fstart();
        px(3, 4);

        cfg(0, 0);
        cfg(2, 3);
        fstart();
        px(0, 0);
        cfg(2, 1);
        fstart();
        px(0, 0);

        cfg(2, 3);
        fstart();
        for (int x = 0; x < 640; x++) begin
            drive(1'b1, 10'(x), 10'd37, (x == 100) ? 1'b1 : 1'b0, 2'd2, 16'd0,
                  (x == 320) ? 1'b1 : 1'b0);
        end

        cfg(2, 1);
        fstart();
        px(5, 6);
        px(7, 8);
        do_reset(2);
        repeat (5) begin
            @(negedge clk);
            chk("post_reset_out_valid", int'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;
        px(9, 9);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  10'($urandom), 10'($urandom),
                  ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)), 16'($urandom),
                  ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_map_reader.md
Name: tile_map_reader

Overview:
Video-side consumer of the 64x64 tile map memory. For every active pixel it computes the scrolled map coordinate and issues a tile-index read. It then issues a pattern read for the returned 7-bit tile index and emits a 4-bit colour index with an opacity flag.
It sits between the VGA timing generator (pixel coordinates, frame strobe) and the layer mixer. Scroll and control values are CPU-written and double-buffered per frame.

Parameters:
MAP_BITS, 6, log2 of map width/height in tiles (map is 64x64)
TILE_IDX_BITS, 7, width of a tile index returned by tile memory
PIXEL_BITS, 4, colour-index width per pattern pixel

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_wen  in  1  CPU config write strobe
cfg_addr  in  2  0=scroll_x, 1=scroll_y, 2=control (bit0 enable, bit1 colour-0-transparent)
cfg_wdata  in  16  config write data; low 9 bits used for scroll, low 2 bits for control
frame_start  in  1  one-cycle strobe at start of vertical blank
in_valid  in  1  pixel coordinate valid this cycle
in_x  in  10  screen x
in_y  in  10  screen y
tile_ren  out  1  tile memory read enable
tile_raddr  out  12  tile memory address {row[5:0], col[5:0]}
tile_rdata  in  7  tile index; valid one cycle after tile_ren
pat_ren  out  1  pattern memory read enable
pat_raddr  out  13  pattern address {tile_idx[6:0], fine_y[2:0], fine_x[2:0]}
pat_rdata  in  4  pattern pixel; valid one cycle after pat_ren
out_valid  out  1  output pixel valid
out_pixel  out  4  colour index
out_opaque  out  1  1 = pixel drawn, 0 = transparent

Behaviour:
- Register pairs: shadow_{scroll_x, scroll_y, ctrl} are written by cfg_wen. active_* take the shadow values on frame_start.
- cfg_wen and frame_start in the same cycle: active takes the pre-write shadow value; the new value waits for the next frame_start.
- A pixel with in_valid in the same cycle as frame_start uses the old active values.
- Coordinate arithmetic, all modulo 512, so the map wraps in both axes:
  - wx = (in_x[8:0] + active_scroll_x[8:0]) mod 512; wy likewise.
  - col = wx[8:3], fine_x = wx[2:0]; row = wy[8:3], fine_y = wy[2:0].
- Pipeline, fixed latency 3, one pixel per cycle, no backpressure:
  - S0 (cycle N): tile_raddr is combinational from in_x/in_y/active scroll. tile_ren = in_valid & active_ctrl.enable. Register valid, enable, fine_x, fine_y, transp into S1.
  - S1 (N+1): pat_raddr = {tile_rdata, s1_fine_y, s1_fine_x}, combinational. pat_ren = s1_valid & s1_enable. Register valid, enable, transp into S2.
  - S2 (N+2): pat_rdata is sampled into output registers.
  - N+3: out_valid = s2_valid. out_pixel = s2_enable ? pat_rdata : 0.
  - N+3: out_opaque = s2_enable & ~(s2_transp & pat_rdata==0).
- Enable and transparency bits travel with each pixel. A frame_start mid-pipeline never alters pixels already in flight.
- Disabled: tile_ren=0, pat_ren=0. out_valid still tracks in_valid with out_pixel=0, out_opaque=0.
- tile_raddr and pat_raddr are don't-care when the matching ren=0. They are driven from current inputs; no gating is required.
- Reset values:
  - all pipeline valids, out_valid, out_pixel and out_opaque = 0;
  - shadow/active scroll = 0; shadow/active ctrl = 0 (disabled);
  - tile_ren = pat_ren = 0.
- Reset asserted mid-pipeline: in-flight pixels are dropped; no out_valid in the cycle after reset.

Decomposition:
- Shared video package: MAP_BITS, TILE_IDX_BITS, PIXEL_BITS, TILE_SHIFT=3, WORLD_BITS=9, cfg address constants (CFG_SCROLL_X=0, CFG_SCROLL_Y=1, CFG_CTRL=2), ctrl bit positions.
- One natural sub-module: tile_scroll_regs (shadow/active double-buffered config registers with frame_start latch). The pipeline stays in tile_map_reader.

Test Plan:
- Enable=1, scroll 0. in_x=17, in_y=9 at cycle N -> tile_raddr=0x042 with tile_ren=1 at N.
  Model tile_rdata=5 at N+1 -> pat_raddr=329, pat_ren=1 at N+1.
  Model pat_rdata=0xA at N+2 -> out_valid=1, out_pixel=0xA, out_opaque=1 at N+3.
- Wrap: active scroll_x=500, in_x=20, in_y=0 -> wx=8: col=1, fine_x=0, tile_raddr=0x001. Also scroll_y=511, in_y=1 -> row 0, fine_y 0.
- Double buffer: write scroll_x=8 -> active stays 0 until frame_start.
  cfg write of 16 coinciding with frame_start -> active=8, then 16 after the next frame_start. Pixel in the frame_start cycle uses 0.
- Transparency: ctrl=3, pat_rdata=0 -> out_opaque=0. ctrl=1, pat_rdata=0 -> out_opaque=1.
- Streaming: 640 consecutive in_valid cycles -> 640 consecutive out_valid cycles, offset by exactly 3. Disabling mid-line via frame_start affects only pixels entering after the latch.
- Reset asserted at N+1 after valid pixels at N-1..N -> out_valid=0 in all following cycles until new in_valid. ctrl back to disabled, so tile_ren=0.
